wb_multi_serializer: RTL and testbench
======================================

// Module: wb_multi_serializer
// PURPOSE
//  Wishbone-slave parallel-to-serial transmitter, next generation of the team's serializer peripheral.
//  Host pushes DW-bit words into a TX FIFO; the block shifts them out MSB- or LSB-first at a programmable bit rate.
//  Per-bit strobe (ena_o) and end-of-word pulse (eobyte_o). Sits on the SoC Wishbone bus, drives a serial sink.
// PARAMETERS
//  DW          8   serial word width, 1..32; TXDATA uses DAT_I[DW-1:0]
//  FIFO_DEPTH  4   TX FIFO entries, power of 2, >=2
//  DIV_W       16  width of the bit-period divider register
// PORTS
//  CLK_I     in   1   system clock
//  RST_NI    in   1   asynchronous active-low reset
//  CYC_I     in   1   Wishbone cycle
//  STB_I     in   1   Wishbone strobe
//  WE_I      in   1   write enable
//  ADR_I     in   32  byte address
//  DAT_I     in   32  write data
//  DAT_O     out  32  read data
//  ACK_O     out  1   acknowledge
//  ERR_O     out  1   error
//  data_o    out  1   serial data
//  ena_o     out  1   one-cycle strobe marking the start of each bit
//  eobyte_o  out  1   one-cycle pulse coincident with ena_o of the last bit of a word
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; CTRL=0; DIV=0; OVF=0; FSM IDLE.
//  Register map (ADR_I[31:4]==0, ADR_I[1:0]==0 required):
//   0x0 CTRL   RW  [0] EN, [1] LSB_FIRST
//   0x4 DIV    RW  [DIV_W-1:0]; bit period = DIV+1 clocks
//   0x8 TXDATA WO  push DAT_I[DW-1:0]; read -> ERR_O
//   0xC STATUS RO  [0] BUSY, [1] EMPTY, [2] FULL, [3] OVF (sticky, write 1 to bit 3 clears), [15:8] LEVEL
//  Bus: ACK_O or ERR_O registered, asserted 1 cycle after CYC_I&STB_I sampled with no ACK/ERR pending; one-cycle pulse.
//   Held request re-acks every 2nd cycle. Unmapped/misaligned address -> ERR_O, no side effect. Unused DAT_O bits 0.
//  Push to full FIFO: ACK_O, word dropped, OVF<=1. Push and pop in the same cycle while full: both succeed, OVF unchanged.
//  FSM IDLE -> SHIFT: EN=1 and FIFO non-empty; pop head into shift register, bit_cnt=DW-1, div_cnt=DIV.
//   IDLE cycle to first ena_o: 1 clock.
//  SHIFT: data_o = shreg MSB (LSB if LSB_FIRST); ena_o=1 on first clock of each bit period; data_o held for DIV+1 clocks.
//  End of bit period: shift, bit_cnt--. Last bit: eobyte_o with its ena_o.
//   Period end: if EN and FIFO non-empty -> pop, next word's first ena_o on the very next clock (no gap); else IDLE.
//  EN cleared mid-word: current word completes, then IDLE.
//  DIV/LSB_FIRST written mid-word: sampled at the next word load only.
//  RST_NI low mid-word: immediate abort, reset values; FIFO contents lost.
//  IDLE: data_o=0, ena_o=0. BUSY=1 while in SHIFT.
//  LEVEL = FIFO occupancy 0..FIFO_DEPTH.
// STRUCTURE
//  Package wb_multi_serializer_pkg:
//   - address localparams ADDR_CTRL/DIV/TXDATA/STATUS
//   - CTRL/STATUS bit-index localparams
//   - typedef enum logic {IDLE, SHIFT} ser_state_e
//  Sub-module ser_tx_fifo:
//   - synchronous FIFO, params W, DEPTH; ports push/pop/din/dout/full/empty/level
//   - async active-low reset
//  Top holds the Wishbone decode, registers and the serializer FSM.
// TESTING
//  1 Reset: RST_NI low mid-run -> all outputs 0, STATUS reads 0x0002, CTRL and DIV read 0.
//  2 DW=8, DIV=0, MSB-first: push 0xA5, EN=1 -> 8 consecutive ena_o, data_o 1,0,1,0,0,1,0,1; eobyte_o on the 8th.
//  3 DIV=3, LSB_FIRST=1: push 0x01 then 0x80 -> data_o held 4 clocks/bit, ena_o every 4th clock.
//    Words back-to-back with no gap; 64 clocks total.
//  4 EN=0, push 5 words (DEPTH=4) -> 5th ACKed; STATUS FULL=1, OVF=1, LEVEL=4.
//    Write 0x8 to STATUS -> OVF=0.
//  5 Read TXDATA, access 0x10, access 0x2 -> ERR_O pulse, no ACK_O, no state change.
//  6 Clear EN after 3 bits of a word, 2 words queued -> word finishes with eobyte_o; no further ena_o; LEVEL stays 2.

Source files
------------

// File: rtl/wb_multi_serializer_pkg.sv
// Shared definitions for the Wishbone serializer: register offsets, bit indices, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wb_multi_serializer_pkg;

  // Register offsets, compared against ADR_I[3:0] once the upper/lower bits are known zero
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_DIV    = 4'h4;
  localparam logic [3:0] ADDR_TXDATA = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  // CTRL bits
  localparam int CTRL_EN        = 0;
  localparam int CTRL_LSB_FIRST = 1;

  // STATUS bits
  localparam int STAT_BUSY   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_FULL   = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_LVL_LO = 8;

  typedef enum logic {IDLE, SHIFT} ser_state_e;

endpackage

// File: rtl/ser_tx_fifo.sv
// Synchronous FIFO holding words waiting to be serialized; dout_o shows the head combinationally.
// Latency: a push is visible at dout_o/level_o the cycle after it is accepted.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/din_i write side;
//        pop_i/dout_o read side; full_o/empty_o/level_o occupancy flags and count.
module ser_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot this cycle, so a simultaneous push into a full FIFO fits.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage needs no reset: it is only read when the count says the entry is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_multi_serializer.sv
// Wishbone-slave parallel-to-serial transmitter: TX FIFO feeding a programmable-rate shifter.
// Latency: ACK/ERR one cycle after request; first ena_o one cycle after the FSM sees EN and data.
// Backpressure: none on the bus (push to full FIFO is ACKed, dropped, flags OVF); serial sink cannot stall.
// Ports: CLK_I/RST_NI clock and async active-low reset; CYC_I/STB_I/WE_I/ADR_I/DAT_I/DAT_O/ACK_O/ERR_O
//        Wishbone slave; data_o serial bit, ena_o bit-start strobe, eobyte_o last-bit strobe.
module wb_multi_serializer
  import wb_multi_serializer_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic        CLK_I,
  input  logic        RST_NI,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        data_o,
  output logic        ena_o,
  output logic        eobyte_o
);

  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW = (DW > 1) ? $clog2(DW) : 1;

  // ---------------- registers ----------------
  logic             en_q, lsb_q, ovf_q;
  logic [DIV_W-1:0] div_q;
  logic             ack_q, err_q;
  logic [31:0]      dat_q;

  // ---------------- FIFO ----------------
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic [LW-1:0] fifo_level;

  ser_tx_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK_I),
    .rst_ni  (RST_NI),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (DAT_I[DW-1:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // ---------------- serializer state ----------------
  ser_state_e       state_q;
  logic [DW-1:0]    shreg_q, sh_next;
  logic [BCW-1:0]   bit_cnt_q;
  logic [DIV_W-1:0] div_cnt_q, div_lat_q;
  logic             lsb_lat_q;
  logic             data_q, ena_q, eob_q;
  logic             period_end, load, first_bit, next_bit;

  assign period_end = (state_q == SHIFT) && (div_cnt_q == '0);
  // Load from IDLE, or straight out of the last bit period so words run back to back.
  assign load = en_q & ~fifo_empty &
                ((state_q == IDLE) | (period_end & (bit_cnt_q == '0)));
  assign fifo_pop = load;

  assign first_bit = lsb_q ? fifo_dout[0] : fifo_dout[DW-1];
  assign sh_next   = lsb_lat_q ? (shreg_q >> 1) : (shreg_q << 1);
  assign next_bit  = lsb_lat_q ? sh_next[0] : sh_next[DW-1];

  // ---------------- bus decode ----------------
  logic        req, addr_ok;
  logic        ack_d, err_d, wr_ctrl, wr_div, clr_ovf;
  logic [31:0] rdata, dat_d;

  // A pending ACK/ERR blocks sampling, so a held request is answered every other cycle.
  assign req     = CYC_I & STB_I & ~ack_q & ~err_q;
  assign addr_ok = (ADR_I[31:4] == 28'd0) && (ADR_I[1:0] == 2'b00);

  always_comb begin
    ack_d     = 1'b0;
    err_d     = 1'b0;
    wr_ctrl   = 1'b0;
    wr_div    = 1'b0;
    clr_ovf   = 1'b0;
    fifo_push = 1'b0;
    rdata     = '0;
    if (req) begin
      if (!addr_ok) begin
        err_d = 1'b1;
      end else begin
        case (ADR_I[3:0])
          ADDR_CTRL: begin
            ack_d = 1'b1;
            if (WE_I) wr_ctrl = 1'b1;
            else begin
              rdata[CTRL_EN]        = en_q;
              rdata[CTRL_LSB_FIRST] = lsb_q;
            end
          end
          ADDR_DIV: begin
            ack_d = 1'b1;
            if (WE_I) wr_div = 1'b1;
            else      rdata[DIV_W-1:0] = div_q;
          end
          ADDR_TXDATA: begin
            if (WE_I) begin
              ack_d     = 1'b1;
              fifo_push = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          ADDR_STATUS: begin
            ack_d = 1'b1;
            if (WE_I) clr_ovf = DAT_I[STAT_OVF];
            else begin
              rdata[STAT_BUSY]            = (state_q == SHIFT);
              rdata[STAT_EMPTY]           = fifo_empty;
              rdata[STAT_FULL]            = fifo_full;
              rdata[STAT_OVF]             = ovf_q;
              rdata[STAT_LVL_LO +: LW]    = fifo_level;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end
    dat_d = (ack_d && !WE_I) ? rdata : 32'd0;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      en_q  <= 1'b0;
      lsb_q <= 1'b0;
      div_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
      if (wr_ctrl) begin
        en_q  <= DAT_I[CTRL_EN];
        lsb_q <= DAT_I[CTRL_LSB_FIRST];
      end
      if (wr_div) div_q <= DAT_I[DIV_W-1:0];
      // Overflow only when the word is really dropped; a same-cycle pop makes room.
      if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      else if (clr_ovf)                          ovf_q <= 1'b0;
    end
  end

  // ---------------- serializer FSM ----------------
  // DIV and LSB_FIRST are latched per word so mid-word writes do not disturb it.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      div_lat_q <= '0;
      lsb_lat_q <= 1'b0;
      data_q    <= 1'b0;
      ena_q     <= 1'b0;
      eob_q     <= 1'b0;
    end else if (load) begin
      state_q   <= SHIFT;
      shreg_q   <= fifo_dout;
      bit_cnt_q <= BCW'(DW - 1);
      div_cnt_q <= div_q;
      div_lat_q <= div_q;
      lsb_lat_q <= lsb_q;
      data_q    <= first_bit;
      ena_q     <= 1'b1;
      eob_q     <= (DW == 1);
    end else if (state_q == SHIFT) begin
      if (div_cnt_q != '0) begin
        div_cnt_q <= div_cnt_q - DIV_W'(1);
        ena_q     <= 1'b0;
        eob_q     <= 1'b0;
      end else if (bit_cnt_q != '0) begin
        shreg_q   <= sh_next;
        bit_cnt_q <= bit_cnt_q - BCW'(1);
        div_cnt_q <= div_lat_q;
        data_q    <= next_bit;
        ena_q     <= 1'b1;
        eob_q     <= (bit_cnt_q == BCW'(1));
      end else begin
        state_q <= IDLE;
        data_q  <= 1'b0;
        ena_q   <= 1'b0;
        eob_q   <= 1'b0;
      end
    end else begin
      data_q <= 1'b0;
      ena_q  <= 1'b0;
      eob_q  <= 1'b0;
    end
  end

  assign DAT_O    = dat_q;
  assign ACK_O    = ack_q;
  assign ERR_O    = err_q;
  assign data_o   = data_q;
  assign ena_o    = ena_q;
  assign eobyte_o = eob_q;

  // Upper write-data bits are intentionally ignored by every register.
  logic unused_dat;
  assign unused_dat = ^DAT_I;

endmodule

// File: tb/tb_wb_multi_serializer.sv
// Self-checking bench for wb_multi_serializer: register table plus serial-stream sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_wb_multi_serializer;

  logic        CLK_I = 1'b0;
  logic        RST_NI = 1'b0;
  logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [31:0] ADR_I = '0, DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK_O, ERR_O, data_o, ena_o, eobyte_o;

  wb_multi_serializer #(.DW(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .CLK_I    (CLK_I),
    .RST_NI   (RST_NI),
    .CYC_I    (CYC_I),
    .STB_I    (STB_I),
    .WE_I     (WE_I),
    .ADR_I    (ADR_I),
    .DAT_I    (DAT_I),
    .DAT_O    (DAT_O),
    .ACK_O    (ACK_O),
    .ERR_O    (ERR_O),
    .data_o   (data_o),
    .ena_o    (ena_o),
    .eobyte_o (eobyte_o)
  );

  always #5 CLK_I = ~CLK_I;

  int n_pass  = 0;
  int n_total = 0;

  // Per-cycle trace of the serial outputs, sampled 2 time units after each rising edge.
  logic tr_ena[$], tr_dat[$], tr_eob[$];
  int   cyc = 0;
  always @(posedge CLK_I) begin
    #2;
    tr_ena.push_back(ena_o);
    tr_dat.push_back(data_o);
    tr_eob.push_back(eobyte_o);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // One bus transfer; waits at most 4 cycles for ACK/ERR. idx = trace index of the
  // sample taken in the cycle after the response.
  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    output logic ack, output logic err, output logic [31:0] rd, output int idx);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
    ack = 1'b0; err = 1'b0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ACK_O || ERR_O) begin
        ack = ACK_O; err = ERR_O; rd = DAT_O;
        break;
      end
    end
    idx = cyc;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [31:0] adr, input logic [31:0] dat, output int idx);
    logic a, e;
    logic [31:0] r;
    wb(1'b1, adr, dat, a, e, r, idx);
    chk(nm, 32'({e, a}), 32'h1);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] adr, input logic [31:0] exp);
    logic a, e;
    logic [31:0] r;
    int idx;
    wb(1'b0, adr, 32'h0, a, e, r, idx);
    chk({nm, "_ack"}, 32'({e, a}), 32'h1);
    chk(nm, r, exp);
  endtask

  task automatic do_reset();
    RST_NI = 1'b0;
    repeat (2) tick();
    RST_NI = 1'b1;
    tick();
  endtask

  // Walk a window of the trace: count ena pulses, collect bits at each ena,
  // note which pulse (1-based) carried eobyte_o.
  task automatic scan(input int start, input int len, output int n_ena, output logic [31:0] bits,
                      output int eob_at, output int n_eob, output int first, output int last);
    n_ena = 0; bits = '0; eob_at = 0; n_eob = 0; first = -1; last = -1;
    for (int i = start; i < start + len; i++) begin
      if (tr_eob[i]) n_eob++;
      if (tr_ena[i]) begin
        n_ena++;
        bits = {bits[30:0], tr_dat[i]};
        if (first < 0) first = i;
        last = i;
        if (tr_eob[i]) eob_at = n_ena;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic e_ack, input logic e_err, input logic [31:0] e_dat);
    vec_t v;
    v.name = n; v.we = we; v.adr = adr; v.dat = dat;
    v.e_ack = e_ack; v.e_err = e_err; v.e_dat = e_dat;
    vecs.push_back(v);
  endtask

  initial begin
    int a, n_ena, eob_at, n_eob, first, last, m_ena, m_dat, m_eob, k0;
    logic [31:0] bits, r;
    logic ack, err;
    logic [15:0] s3;

    // ---- register table: reset values, bus errors, FIFO overflow ----
    add("rst_status", 0, 32'hC,  32'h0,    1, 0, 32'h0002);
    add("rst_ctrl",   0, 32'h0,  32'h0,    1, 0, 32'h0);
    add("rst_div",    0, 32'h4,  32'h0,    1, 0, 32'h0);
    add("wr_div",     1, 32'h4,  32'h1234, 1, 0, 32'h0);
    add("rd_div",     0, 32'h4,  32'h0,    1, 0, 32'h1234);
    add("rd_txdata",  0, 32'h8,  32'h0,    0, 1, 32'h0);
    add("acc_0x10",   0, 32'h10, 32'h0,    0, 1, 32'h0);
    add("wr_0x2",     1, 32'h2,  32'hFFFF, 0, 1, 32'h0);
    add("div_kept",   0, 32'h4,  32'h0,    1, 0, 32'h1234);
    add("status_kept",0, 32'hC,  32'h0,    1, 0, 32'h0002);
    add("push1",      1, 32'h8,  32'h11,   1, 0, 32'h0);
    add("push2",      1, 32'h8,  32'h12,   1, 0, 32'h0);
    add("push3",      1, 32'h8,  32'h13,   1, 0, 32'h0);
    add("push4",      1, 32'h8,  32'h14,   1, 0, 32'h0);
    add("push5_ovf",  1, 32'h8,  32'h15,   1, 0, 32'h0);
    add("st_full",    0, 32'hC,  32'h0,    1, 0, 32'h040C);
    add("clr_ovf",    1, 32'hC,  32'h8,    1, 0, 32'h0);
    add("st_cleared", 0, 32'hC,  32'h0,    1, 0, 32'h0404);
    add("wr_ctrl",    1, 32'h0,  32'h2,    1, 0, 32'h0);
    add("rd_ctrl",    0, 32'h0,  32'h0,    1, 0, 32'h2);

    do_reset();
    chk("rst_outputs", 32'({data_o, ena_o, eobyte_o, ACK_O, ERR_O}), 32'h0);
    foreach (vecs[i]) begin
      wb(vecs[i].we, vecs[i].adr, vecs[i].dat, ack, err, r, a);
      chk({vecs[i].name, "_ack"}, 32'(ack), 32'(vecs[i].e_ack));
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].e_err));
      chk({vecs[i].name, "_dat"}, r, vecs[i].e_dat);
    end

    // ---- DIV=0 MSB-first 0xA5 ----
    do_reset();
    wr("t2_div", 32'h4, 32'h0, a);
    wr("t2_push", 32'h8, 32'hA5, a);
    wr("t2_en", 32'h0, 32'h1, a);
    repeat (16) tick();
    scan(a, 14, n_ena, bits, eob_at, n_eob, first, last);
    chk("t2_first_ena", 32'(first), 32'(a + 1));
    chk("t2_n_ena", 32'(n_ena), 32'd8);
    chk("t2_consecutive", 32'(last - first), 32'd7);
    chk("t2_bits", bits, 32'hA5);
    chk("t2_eob_pos", 32'(eob_at), 32'd8);
    chk("t2_n_eob", 32'(n_eob), 32'd1);
    chk("t2_idle_data", 32'(tr_dat[a + 9]), 32'h0);

    // ---- reset mid-word ----
    wr("t1_div", 32'h4, 32'h5, a);
    wr("t1_push", 32'h8, 32'hFF, a);
    repeat (3) tick();
    chk("t1_pre_data", 32'(data_o), 32'h1);
    RST_NI = 1'b0;
    #1;
    chk("t1_outs_in_rst", 32'({data_o, ena_o, eobyte_o, ACK_O, ERR_O}), 32'h0);
    chk("t1_dato_in_rst", DAT_O, 32'h0);
    repeat (2) tick();
    RST_NI = 1'b1;
    k0 = cyc;
    tick();
    rd_chk("t1_status", 32'hC, 32'h0002);
    rd_chk("t1_ctrl", 32'h0, 32'h0);
    rd_chk("t1_div", 32'h4, 32'h0);
    repeat (10) tick();
    scan(k0, cyc - k0, n_ena, bits, eob_at, n_eob, first, last);
    chk("t1_no_ena_after", 32'(n_ena), 32'd0);

    // ---- DIV=3 LSB-first 0x01 then 0x80, back to back ----
    wr("t3_div", 32'h4, 32'h3, a);
    wr("t3_ctrl_lsb", 32'h0, 32'h2, a);
    wr("t3_push0", 32'h8, 32'h01, a);
    wr("t3_push1", 32'h8, 32'h80, a);
    wr("t3_en", 32'h0, 32'h3, a);
    repeat (70) tick();
    s3 = 16'h8001;  // bit j is the j-th bit on the wire
    m_ena = 0; m_dat = 0; m_eob = 0;
    for (int k = 0; k < 64; k++) begin
      if (tr_ena[a + 1 + k] !== (k % 4 == 0)) m_ena++;
      if (tr_dat[a + 1 + k] !== s3[k / 4]) m_dat++;
      if (tr_eob[a + 1 + k] !== (k == 28 || k == 60)) m_eob++;
    end
    chk("t3_no_early_ena", 32'(tr_ena[a]), 32'h0);
    chk("t3_ena_mismatch", 32'(m_ena), 32'd0);
    chk("t3_dat_mismatch", 32'(m_dat), 32'd0);
    chk("t3_eob_mismatch", 32'(m_eob), 32'd0);
    chk("t3_idle_ena", 32'(tr_ena[a + 65]), 32'h0);
    chk("t3_idle_dat", 32'(tr_dat[a + 65]), 32'h0);

    // ---- EN cleared mid-word with 2 words queued ----
    wr("t6_dis", 32'h0, 32'h0, a);
    wr("t6_push0", 32'h8, 32'hC3, a);
    wr("t6_push1", 32'h8, 32'h5A, a);
    wr("t6_push2", 32'h8, 32'h3C, a);
    wr("t6_en", 32'h0, 32'h1, a);
    repeat (10) tick();
    wr("t6_clr_en", 32'h0, 32'h0, k0);
    repeat (55) tick();
    scan(a, 60, n_ena, bits, eob_at, n_eob, first, last);
    chk("t6_first_ena", 32'(first), 32'(a + 1));
    chk("t6_n_ena", 32'(n_ena), 32'd8);
    chk("t6_bits", bits, 32'hC3);
    chk("t6_eob_pos", 32'(eob_at), 32'd8);
    chk("t6_n_eob", 32'(n_eob), 32'd1);
    rd_chk("t6_status", 32'hC, 32'h0200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
